// File: rtl/rx_shift_fifo.sv
// rx_shift_fifo: UART RX deserialiser committing frames into a FWFT FIFO.
// Optional per-entry parity checking when RX_SHFT_PARITY_EN is defined.
module rx_shift_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                     CLOCK,
  input  logic                     reset_n,
  input  logic                     Rx,
  input  logic                     shift,
  input  logic                     load_buffer,
  input  logic                     Rd_en,
  input  logic                     clr_ovrflw,
  output logic [DATA_W-1:0]        rx_data_out,
  output logic                     d_valid,
  output logic                     parity_err,
  output logic                     overflow,
  output logic                     short_frame,
  output logic [$clog2(DEPTH):0]   fill_level
);
`ifdef RX_SHFT_PARITY_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(FW + 1);
  logic [FW-1:0] sr_q, sr_d, wdata, head;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, shf_q, shf_d, pop, push, frame_ok;
  logic [FW-1:0] mem_q [DEPTH];
`ifdef RX_SHFT_PARITY_EN
  assign wdata = {^sr_q ^ PARITY_ODD[0], sr_q[DATA_W-1:0]};
  assign parity_err = d_valid & head[FW-1];
`else
  logic unused_parity;
  assign unused_parity = PARITY_ODD[0];
  assign wdata = sr_q;
  assign parity_err = 1'b0;
`endif
  always_comb begin
    frame_ok = bcnt_q == BW'(FW);
    pop = Rd_en && cnt_q != '0;
    push = load_buffer && frame_ok && (cnt_q != (AW+1)'(DEPTH) || pop);
    sr_d = shift ? {Rx, sr_q[FW-1:1]} : sr_q;
    bcnt_d = load_buffer ? BW'(shift) : (shift && !frame_ok) ? bcnt_q + BW'(1) : bcnt_q;
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (load_buffer && frame_ok && !push) || (ovf_q && !clr_ovrflw);
    shf_d = (load_buffer && !frame_ok) || (shf_q && !clr_ovrflw);
  end
  always_ff @(posedge CLOCK) begin
    if (!reset_n) begin
      sr_q <= '0;
      bcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      shf_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      bcnt_q <= bcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      shf_q <= shf_d;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
  // memory is never cleared, so the head is masked while empty
  assign head = mem_q[rptr_q];
  assign d_valid = cnt_q != '0;
  assign rx_data_out = d_valid ? head[DATA_W-1:0] : '0;
  assign overflow = ovf_q;
  assign short_frame = shf_q;
  assign fill_level = cnt_q;
endmodule

// File: tb/tb_rx_shift_fifo.sv
// tb_rx_shift_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_rx_shift_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
`ifdef RX_SHFT_PARITY_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  logic CLOCK = 0, reset_n = 0, Rx = 0, shift = 0, load_buffer = 0, Rd_en = 0, clr_ovrflw = 0;
  logic [DATA_W-1:0] rx_data_out;
  logic d_valid, parity_err, overflow, short_frame;
  logic [$clog2(DEPTH):0] fill_level;
  int checks = 0, errors = 0;
  rx_shift_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PARITY_ODD(0)) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .Rx(Rx), .shift(shift), .load_buffer(load_buffer),
    .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw), .rx_data_out(rx_data_out), .d_valid(d_valid),
    .parity_err(parity_err), .overflow(overflow), .short_frame(short_frame), .fill_level(fill_level)
  );
  initial forever #5 CLOCK = ~CLOCK;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  int q_d[$];
  bit q_p[$];
  bit bitq[$];
  int nsince;
  bit m_ovf, m_short, started;
  always @(posedge CLOCK) begin
    bit pop, do_push, ovf_set, sh_set, p;
    int d;
    started = 1;
    if (!reset_n) begin
      q_d.delete(); q_p.delete(); bitq.delete();
      nsince = 0; m_ovf = 0; m_short = 0;
    end else begin
      pop = Rd_en && q_d.size() > 0;
      do_push = 0; ovf_set = 0; sh_set = 0;
      if (load_buffer) begin
        if (nsince < FW) sh_set = 1;
        else if (q_d.size() == DEPTH && !pop) ovf_set = 1;
        else do_push = 1;
      end
      if (pop) begin void'(q_d.pop_front()); void'(q_p.pop_front()); end
      if (do_push) begin
        d = 0; p = 0;
        for (int i = 0; i < FW; i++) begin
          if (i < DATA_W) d += int'(bitq[i]) << i;
          p ^= bitq[i];
        end
        q_d.push_back(d);
`ifdef RX_SHFT_PARITY_EN
        q_p.push_back(p);
`else
        q_p.push_back(0);
`endif
      end
      if (clr_ovrflw) begin m_ovf = 0; m_short = 0; end
      if (ovf_set) m_ovf = 1;
      if (sh_set) m_short = 1;
      nsince = load_buffer ? int'(shift) : nsince + int'(shift);
      if (shift) begin
        bitq.push_back(Rx);
        if (bitq.size() > FW) void'(bitq.pop_front());
      end
    end
  end
  always @(negedge CLOCK) begin
    if (started) begin
      chk("m_d_valid", int'(d_valid), int'(q_d.size() > 0));
      chk("m_data", int'(rx_data_out), q_d.size() > 0 ? q_d[0] : 0);
      chk("m_parity_err", int'(parity_err), q_p.size() > 0 ? int'(q_p[0]) : 0);
      chk("m_overflow", int'(overflow), int'(m_ovf));
      chk("m_short_frame", int'(short_frame), int'(m_short));
      chk("m_fill_level", int'(fill_level), q_d.size());
    end
  end
  task automatic shift_bits(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      Rx = v[i]; shift = 1;
      @(negedge CLOCK);
    end
    shift = 0; Rx = 0;
  endtask
  task automatic load();
    load_buffer = 1;
    @(negedge CLOCK);
    load_buffer = 0;
  endtask
  task automatic send(input int d, input int p);
    shift_bits(d, DATA_W);
`ifdef RX_SHFT_PARITY_EN
    shift_bits(p, 1);
`endif
    load();
  endtask
  task automatic pop_one();
    Rd_en = 1;
    @(negedge CLOCK);
    Rd_en = 0;
  endtask
  function automatic int par(input int d);
    return int'(^d[DATA_W-1:0]);
  endfunction
  initial begin
    repeat (2) @(negedge CLOCK);
    chk("reset_d_valid", int'(d_valid), 0);
    chk("reset_fill", int'(fill_level), 0);
    reset_n = 1;
    send(8'hA5, par(8'hA5));
    chk("basic_valid", int'(d_valid), 1);
    chk("basic_data", int'(rx_data_out), 8'hA5);
    chk("basic_fill", int'(fill_level), 1);
    pop_one();
    chk("basic_pop_valid", int'(d_valid), 0);
    for (int i = 1; i <= 5; i++) send(i, par(i));
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_fill", int'(fill_level), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_readback", int'(rx_data_out), i);
      pop_one();
    end
    chk("ovf_empty", int'(d_valid), 0);
    clr_ovrflw = 1; @(negedge CLOCK); clr_ovrflw = 0;
    chk("ovf_clear", int'(overflow), 0);
    for (int i = 8'h10; i <= 8'h13; i++) send(i, par(i));
    shift_bits(8'h14, DATA_W);
`ifdef RX_SHFT_PARITY_EN
    shift_bits(par(8'h14), 1);
`endif
    Rd_en = 1; load_buffer = 1;
    @(negedge CLOCK);
    Rd_en = 0; load_buffer = 0;
    chk("full_pp_ovf", int'(overflow), 0);
    chk("full_pp_fill", int'(fill_level), 4);
    for (int i = 8'h11; i <= 8'h14; i++) begin
      chk("full_pp_order", int'(rx_data_out), i);
      pop_one();
    end
    pop_one();
    chk("empty_pop_fill", int'(fill_level), 0);
    shift_bits(5'h1F, 5);
    load();
    chk("short_set", int'(short_frame), 1);
    chk("short_fill", int'(fill_level), 0);
    shift_bits(2'b11, 2);
    clr_ovrflw = 1; load_buffer = 1;
    @(negedge CLOCK);
    clr_ovrflw = 0; load_buffer = 0;
    chk("short_set_wins", int'(short_frame), 1);
    clr_ovrflw = 1; @(negedge CLOCK); clr_ovrflw = 0;
    chk("short_clear", int'(short_frame), 0);
    shift_bits(0, 7);
    Rx = 1; shift = 1; load_buffer = 1;
    @(negedge CLOCK);
    Rx = 0; shift = 0; load_buffer = 0;
    chk("shift_load_short", int'(short_frame), 1);
    shift_bits(8'h40, 7);
`ifdef RX_SHFT_PARITY_EN
    shift_bits(0, 1);
`endif
    load();
    chk("shift_load_data", int'(rx_data_out), 8'h81);
    pop_one();
    clr_ovrflw = 1; @(negedge CLOCK); clr_ovrflw = 0;
`ifdef RX_SHFT_PARITY_EN
    send(8'h03, 1);
    chk("parity_bad", int'(parity_err), 1);
    pop_one();
    send(8'h03, 0);
    chk("parity_good", int'(parity_err), 0);
    pop_one();
`endif
    send(8'h11, par(8'h11));
    send(8'h22, par(8'h22));
    shift_bits(3'b101, 3);
    reset_n = 0; @(negedge CLOCK); reset_n = 1;
    chk("rst_valid", int'(d_valid), 0);
    chk("rst_data", int'(rx_data_out), 0);
    chk("rst_fill", int'(fill_level), 0);
    chk("rst_flags", int'({overflow, short_frame, parity_err}), 0);
    send(8'h3C, par(8'h3C));
    chk("post_rst_data", int'(rx_data_out), 8'h3C);
    chk("post_rst_fill", int'(fill_level), 1);
    @(negedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
